// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, FSM state type and lane helpers for the load/store unit.
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // REQ1/WAIT1 are only reachable when misaligned splitting is compiled in
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_t;

    // Byte-enable pattern over an 8-byte window: size is funct3[1:0]
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'b0000_0001;
            2'b01:   base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << off;
    endfunction

    // Unsigned loads have no store counterpart; 011/11x are unused encodings
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response and word-wide data-memory handshake.
// slave = the load/store unit's view, master = the CPU + memory environment.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 30
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half/word out of a byte window and extends it.
// The window is 7 bytes: enough for any 4-byte read starting at offset 0..3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [55:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign shifted[8*gi +: 8] = window[{offset, 3'b000} + 8*gi +: 8];
        end
    endgenerate

    // Sign- or zero-extend according to the access size
    always_comb begin
        data = 32'b0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = 32'b0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between the CPU datapath and a
// handshaked word-wide data memory. Define LSU_MISALIGN_SPLIT_EN to turn
// misaligned H/W accesses into two word accesses instead of an error response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 30
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    lsu_state_t        state_reg, state_next;
    logic              we_reg;
    logic [2:0]        f3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       resp_rdata_reg;
    logic              resp_err_reg;

    logic              accept;
    logic              req_legal;
    logic              req_misaligned;
    logic              req_err;
    logic              split_flag;
    logic              last_beat;
    logic              second_word;
    logic [1:0]        off;
    logic [7:0]        mask8;
    logic [31:0]       lane_wdata;
    logic [55:0]       load_window;
    logic [31:0]       load_data;

    assign accept         = bus.req_valid && (state_reg == IDLE);
    assign req_legal      = funct3_legal(bus.req_we, bus.req_funct3);
    assign req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign off            = addr_reg[1:0];
    assign mask8          = lane_mask(f3_reg[1:0], off);
    assign second_word    = (state_reg == REQ1);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_reg;
    logic [31:0] lo_reg;
    logic [63:0] split_wdata;

    assign split_flag  = split_reg;
    assign split_wdata = {32'b0, wdata_reg} << {off, 3'b000};
    assign load_window = split_reg ? {bus.mem_rdata[23:0], lo_reg} : {24'b0, bus.mem_rdata};
    assign req_err     = !req_legal;

    // Remember whether this access spans two words and keep the first word of a split load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_reg <= 1'b0;
            lo_reg    <= 32'b0;
        end else begin
            if (accept)
                split_reg <= req_legal && req_misaligned;
            if ((state_reg == WAIT0) && bus.mem_rvalid)
                lo_reg <= bus.mem_rdata;
        end
    end
`else
    assign split_flag  = 1'b0;
    assign load_window = {24'b0, bus.mem_rdata};
    assign req_err     = !req_legal || req_misaligned;
`endif

    // Store data onto its byte lanes: B/H replicated across the word, split accesses from the 8-byte window
    always_comb begin
        case (f3_reg[1:0])
            2'b00:   lane_wdata = {4{wdata_reg[7:0]}};
            2'b01:   lane_wdata = {2{wdata_reg[15:0]}};
            default: lane_wdata = wdata_reg;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_reg)
            lane_wdata = second_word ? split_wdata[63:32] : split_wdata[31:0];
`endif
    end

    lsu_load_align u_load_align (
        .window (load_window),
        .offset (off),
        .funct3 (f3_reg),
        .data   (load_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next state; last_beat marks the memory response that completes the access
    always_comb begin
        state_next = state_reg;
        last_beat  = 1'b0;
        case (state_reg)
            IDLE:  if (accept) state_next = req_err ? RESP : REQ0;
            REQ0:  if (bus.mem_gnt) state_next = WAIT0;
            WAIT0: if (bus.mem_rvalid) begin
                       if (split_flag) begin
                           state_next = REQ1;
                       end else begin
                           state_next = RESP;
                           last_beat  = 1'b1;
                       end
                   end
            REQ1:  if (bus.mem_gnt) state_next = WAIT1;
            WAIT1: if (bus.mem_rvalid) begin
                       state_next = RESP;
                       last_beat  = 1'b1;
                   end
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Interface outputs: memory fields come from registered request, so they stay stable until grant
    always_comb begin
        bus.req_ready  = (state_reg == IDLE);
        bus.resp_valid = (state_reg == RESP);
        bus.resp_rdata = resp_rdata_reg;
        bus.resp_err   = resp_err_reg;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_be     = 4'b0;
        bus.mem_wdata  = 32'b0;
        if ((state_reg == REQ0) || (state_reg == REQ1)) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_reg;
            bus.mem_addr  = MEM_AW'(addr_reg[ADDR_W-1:2]) + MEM_AW'(second_word);
            bus.mem_be    = second_word ? mask8[7:4] : mask8[3:0];
            bus.mem_wdata = we_reg ? lane_wdata : 32'b0;
        end
    end

    // Capture the request on accept and the response value when the access completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg         <= 1'b0;
            f3_reg         <= 3'b0;
            addr_reg       <= '0;
            wdata_reg      <= 32'b0;
            resp_rdata_reg <= 32'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                we_reg    <= bus.req_we;
                f3_reg    <= bus.req_funct3;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
                if (req_err) begin
                    resp_rdata_reg <= 32'b0;
                    resp_err_reg   <= 1'b1;
                end
            end
            if (last_beat) begin
                resp_rdata_reg <= we_reg ? 32'b0 : load_data;
                resp_err_reg   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses against a byte-level reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    load_store_unit_if #(.ADDR_W(32), .MEM_AW(30)) bus ();

    load_store_unit #(.ADDR_W(32), .MEM_AW(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal_f3(input bit we, input logic [2:0] f3);
        if (f3 == F3_B || f3 == F3_H || f3 == F3_W) return 1'b1;
        if (f3 == F3_BU || f3 == F3_HU) return !we;
        return 1'b0;
    endfunction

    // Gather size bytes starting at the offset in the {w1,w0} byte stream, then extend
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] win;
        longint      v;
        int          sz;
        win = {w1, w0};
        v   = 0;
        sz  = size_of(f3);
        for (int i = 0; i < sz; i++)
            v += longint'(win[8*(off+i) +: 8]) << (8*i);
        if ((f3 == F3_B || f3 == F3_H) && v[8*sz-1])
            v = v - (longint'(1) << (8*sz));
        return v[31:0];
    endfunction

    // One complete access; starts and ends just after a falling edge with the unit idle
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int gdly, input int rdly,
                          input logic [31:0] rd0, input logic [31:0] rd1);
        int          sz, off, nw;
        bit          err, mis;
        logic [3:0]  ebe[2];
        logic [31:0] ewd[2];
        logic [31:0] emask[2];
        logic [29:0] ewa[2];
        logic [31:0] erd;

        sz  = size_of(f3);
        off = int'(addr[1:0]);
        mis = (off % sz) != 0;
        err = !legal_f3(we, f3) || (mis && !SPLIT);
        nw  = mis ? 2 : 1;
        for (int k = 0; k < 2; k++) begin
            ebe[k]   = 4'b0;
            ewd[k]   = 32'b0;
            emask[k] = 32'b0;
            ewa[k]   = addr[31:2] + 30'(k);
        end
        for (int i = 0; i < sz; i++) begin
            int p;
            p = off + i;
            ebe[p/4][p%4] = 1'b1;
            if (nw == 2) begin
                ewd[p/4][8*(p%4) +: 8]   = wd[8*i +: 8];
                emask[p/4][8*(p%4) +: 8] = 8'hFF;
            end
        end
        if (nw == 1) begin
            for (int l = 0; l < 4; l++)
                ewd[0][8*l +: 8] = wd[8*(l % sz) +: 8];
            emask[0] = 32'hFFFF_FFFF;
        end
        erd = (err || we) ? 32'b0 : exp_load(f3, off, rd0, rd1);

        check("ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_we     = ~we;
        check("ready_busy", bus.req_ready, 0);

        if (err) begin
            check("err_resp_valid", bus.resp_valid, 1);
            check("err_resp_err", bus.resp_err, 1);
            check("err_resp_rdata", bus.resp_rdata, 0);
            check("err_no_mem_req", bus.mem_req, 0);
        end else begin
            for (int k = 0; k < nw; k++) begin
                for (int c = 0; c <= gdly; c++) begin
                    check("mem_req_held", bus.mem_req, 1);
                    check("mem_addr", 32'(bus.mem_addr), 32'(ewa[k]));
                    check("mem_be", 32'(bus.mem_be), 32'(ebe[k]));
                    check("mem_we", bus.mem_we, we);
                    if (we)
                        check("mem_wdata", bus.mem_wdata & emask[k], ewd[k] & emask[k]);
                    check("no_early_resp", bus.resp_valid, 0);
                    bus.mem_gnt    = (c == gdly);
                    bus.mem_rvalid = (c != gdly);
                    @(negedge clk);
                end
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b0;
                for (int c = 0; c < rdly; c++) begin
                    check("wait_mem_req_low", bus.mem_req, 0);
                    check("wait_no_resp", bus.resp_valid, 0);
                    bus.mem_gnt = 1'b1;
                    @(negedge clk);
                end
                check("rv_mem_req_low", bus.mem_req, 0);
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = (k == 0) ? rd0 : rd1;
                @(negedge clk);
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end
            check("resp_valid", bus.resp_valid, 1);
            check("resp_err", bus.resp_err, 0);
            check("resp_rdata", bus.resp_rdata, erd);
        end
        @(negedge clk);
        check("resp_one_cycle", bus.resp_valid, 0);
        check("ready_after", bus.req_ready, 1);
        check("rdata_hold", bus.resp_rdata, erd);
        check("err_hold", bus.resp_err, err);
        $display("txn we=%0d f3=%03b addr=%08h wdata=%08h gnt_dly=%0d rv_dly=%0d -> rdata=%08h err=%0d",
                 we, f3, addr, wd, gdly, rdly, bus.resp_rdata, bus.resp_err);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'b0;
        bus.req_wdata  = 32'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", bus.resp_err, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_be", 32'(bus.mem_be), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // LB at 0x103: top byte 0x80 sign-extends
        access(1'b0, F3_B, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234, 32'h0);
        check("lb_value", bus.resp_rdata, 32'hFFFF_FF80);

        // Asynchronous reset while waiting for read data; the late rvalid must be ignored
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h0000_0100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mw_req", bus.mem_req, 1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("mw_wait_req_low", bus.mem_req, 0);
        #1 rst = 1'b1;
        #1;
        check("mw_rst_ready", bus.req_ready, 1);
        check("mw_rst_mem_req", bus.mem_req, 0);
        check("mw_rst_resp_valid", bus.resp_valid, 0);
        check("mw_rst_rdata", bus.resp_rdata, 0);
        @(negedge clk);
        rst            = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mw_no_resp", bus.resp_valid, 0);
            check("mw_idle_ready", bus.req_ready, 1);
            check("mw_idle_mem_req", bus.mem_req, 0);
            @(negedge clk);
        end

        // SH at 0x202 with a slow grant
        access(1'b1, F3_H, 32'h0000_0202, 32'h0000_BEEF, 4, 0, 32'h0, 32'h0);

        // LHU / LH of the same half-word
        access(1'b0, F3_HU, 32'h0000_0010, 32'h0, 1, 2, 32'h1234_F00D, 32'h0);
        check("lhu_value", bus.resp_rdata, 32'h0000_F00D);
        access(1'b0, F3_H, 32'h0000_0010, 32'h0, 0, 1, 32'h1234_F00D, 32'h0);
        check("lh_value", bus.resp_rdata, 32'hFFFF_F00D);

        // Misaligned LW: error, or merged from two words when splitting
        access(1'b0, F3_W, 32'h0000_0006, 32'h0, 0, 0, 32'h4433_2211, 32'h8877_6655);
        check("lw_mis_value", bus.resp_rdata, SPLIT ? 32'h6655_4433 : 32'h0);

        // Misaligned word at the top of the address space (wraps when split)
        access(1'b0, F3_W, 32'hFFFF_FFFF, 32'h0, 1, 0, 32'hAABB_CCDD, 32'h1122_3344);
        access(1'b1, F3_H, 32'h0000_0033, 32'h0000_A55A, 0, 1, 32'h0, 32'h0);

        // Illegal: unsigned store
        access(1'b1, F3_BU, 32'h0000_0040, 32'h1234_5678, 0, 0, 32'h0, 32'h0);

        // Back-to-back with req_valid held: second accepted the cycle after resp_valid
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_HU;
        bus.req_addr   = 32'h0000_0040;
        @(negedge clk);
        check("b2b_first_resp", bus.resp_valid, 1);
        check("b2b_first_err", bus.resp_err, 1);
        check("b2b_busy", bus.req_ready, 0);
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b011;
        @(negedge clk);
        check("b2b_ready", bus.req_ready, 1);
        check("b2b_gap", bus.resp_valid, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_second_resp", bus.resp_valid, 1);
        check("b2b_second_err", bus.resp_err, 1);
        @(negedge clk);
        check("b2b_done", bus.resp_valid, 0);

        // Randomized accesses
        for (int t = 0; t < 60; t++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            bit          we;
            int          pick;
            pick = $urandom_range(0, 11);
            case (pick)
                0: f3 = F3_B;
                1: f3 = F3_H;
                2: f3 = F3_W;
                3: f3 = F3_BU;
                4: f3 = F3_HU;
                5: f3 = 3'b011;
                6: f3 = 3'b110;
                7: f3 = 3'b111;
                8: f3 = F3_B;
                9: f3 = F3_H;
                default: f3 = F3_W;
            endcase
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            access(we, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
